// File: rtl/seq_approx_divider_if.sv
// Operand/result handshake bundle for seq_approx_divider.
// slave: divider side (takes in_*/n/d, drives out_*/q/r/ovf/dz); master: user side.
interface seq_approx_divider_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] n;
  logic [W-1:0]   d;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           ovf;
  logic           dz;

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r, ovf, dz
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r, ovf, dz
  );
endinterface

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider (2W / W), ROWS_PER_CYCLE rows per clock.
// Ports: clk, rst_n (async low), bus (slave modport: in_valid/in_ready/n/d,
// out_valid/out_ready/q/r/ovf/dz). Low quotient rows may use approximate
// subtractor cells; define SEQ_APPROX_DIV_FORCE_EXACT_EN for an all-exact build.
module seq_approx_divider #(
  parameter int W              = 8,
  parameter int ROWS_PER_CYCLE = 1,
  parameter int APPROX_ROWS    = 0,
  parameter int APPROX_COLS    = W
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_approx_divider_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_TOP  = KW'(W - 1);
  localparam logic [KW-1:0] K_LAST = KW'(ROWS_PER_CYCLE - 1);

`ifdef SEQ_APPROX_DIV_FORCE_EXACT_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic [1:0]    r_state;
  logic          r_live;
  logic [W:0]    r_win;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_qw;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_nlo;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_ovf;
  logic          r_dz;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;
  logic [W:0]    w_row;
  logic [W:0]    w_win_nx;
  logic [W-1:0]  w_lo_nx;
  logic [W-1:0]  w_qw_nx;
  logic [W-1:0]  w_rem;

  // One subtractor row: returns {quotient bit, new partial remainder}.
  function automatic logic [W:0] row_eval(
    input logic [W:0]   win,
    input logic [W-1:0] dv,
    input logic         apx
  );
    logic         b;
    logic         x;
    logic         y;
    logic         ap;
    logic         qb;
    logic [W-1:0] diff;
    b    = 1'b0;
    diff = '0;
    for (int j = 0; j < W; j++) begin
      x  = win[j];
      y  = dv[j];
      ap = !EXACT && apx && (j < APPROX_COLS);
      if (ap) begin
        diff[j] = y;
        b       = x & ~y;
      end else begin
        diff[j] = x ^ y ^ b;
        b       = (~x & y) | (~(x ^ y) & b);
      end
    end
    qb = win[W] | ~b;
    return {qb, qb ? diff : win[W-1:0]};
  endfunction

  assign w_in_ready = r_live &
                      ((r_state == S_IDLE) |
                       ((r_state == S_DONE) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_last     = (r_k == K_LAST);

  // Chain this cycle's rows; the next window is {R, next dividend bit}.
  always_comb begin
    w_win_nx = r_win;
    w_lo_nx  = r_lo;
    w_qw_nx  = r_qw;
    w_rem    = '0;
    w_row    = '0;
    for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
      w_row    = row_eval(w_win_nx, r_d,
                          (int'(r_k) - i) < APPROX_ROWS);
      w_qw_nx  = {w_qw_nx[W-2:0], w_row[W]};
      w_rem    = w_row[W-1:0];
      w_win_nx = {w_rem, w_lo_nx[W-1]};
      w_lo_nx  = {w_lo_nx[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_win   <= '0;
      r_lo    <= '0;
      r_qw    <= '0;
      r_d     <= '0;
      r_nlo   <= '0;
      r_k     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_CALC: begin
          r_win <= w_win_nx;
          r_lo  <= w_lo_nx;
          r_qw  <= w_qw_nx;
          r_k   <= r_k - KW'(ROWS_PER_CYCLE);
          if (w_last) begin
            r_state <= S_DONE;
            r_q     <= r_dz ? '1 : w_qw_nx;
            r_r     <= r_dz ? r_nlo : w_rem;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: ;
      endcase
      if (w_accept) begin
        r_state <= S_CALC;
        r_win   <= bus.n[2*W-1:W-1];
        r_lo    <= {bus.n[W-2:0], 1'b0};
        r_qw    <= '0;
        r_d     <= bus.d;
        r_nlo   <= bus.n[W-1:0];
        r_k     <= K_TOP;
        r_ovf   <= (bus.n[2*W-1:W] >= bus.d);
        r_dz    <= (bus.d == '0);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Bench for seq_approx_divider: four configurations driven from shared
// operands, checked against an arithmetic/bit-level reference model.
module tb_seq_approx_divider;

  localparam int ND = 4;
  localparam int P_RPC [ND] = '{1, 4, 2, 1};
  localparam int P_AR  [ND] = '{0, 0, 8, 4};
  localparam int P_AC  [ND] = '{8, 8, 8, 5};

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] iv;
  logic [ND-1:0] ordy;
  logic [15:0]   tn;
  logic [7:0]    td;

  wire [ND-1:0]  ov;
  wire [ND-1:0]  ir;
  wire [ND-1:0]  ovfo;
  wire [ND-1:0]  dzo;
  wire [7:0]     qo [ND];
  wire [7:0]     ro [ND];

  int n_checks;
  int n_err;

  for (genvar g = 0; g < ND; g++) begin : gd
    seq_approx_divider_if #(.W(8)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.out_ready = ordy[g];
    assign bus.n         = tn;
    assign bus.d         = td;
    assign ov[g]         = bus.out_valid;
    assign ir[g]         = bus.in_ready;
    assign ovfo[g]       = bus.ovf;
    assign dzo[g]        = bus.dz;
    assign qo[g]         = bus.q;
    assign ro[g]         = bus.r;
    seq_approx_divider #(
      .W(8),
      .ROWS_PER_CYCLE(P_RPC[g]),
      .APPROX_ROWS(P_AR[g]),
      .APPROX_COLS(P_AC[g])
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact rows by integer compare/subtract, approximate rows
  // column by column from the cell rules.
  function automatic void model(
    input  logic [15:0] n,
    input  logic [7:0]  d,
    input  int          ar,
    input  int          ac,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        dz
  );
    int rem, top, low, nr, bo, t, x, y;
    logic [7:0] dif;
    bit take;
    ovf = (n[15:8] >= d);
    dz  = (d == 8'd0);
    q   = '0;
    r   = '0;
`ifdef SEQ_APPROX_DIV_FORCE_EXACT_EN
    ar = 0;
`endif
    if (dz) begin
      q = 8'hFF;
      r = n[7:0];
      return;
    end
    rem = int'(n[15:7]);
    for (int k = 7; k >= 0; k--) begin
      top = rem / 256;
      low = rem % 256;
      if (k >= ar) begin
        take = (top == 1) || (low >= int'(d));
        nr   = take ? (low - int'(d) + 256) % 256 : low;
      end else begin
        bo  = 0;
        dif = '0;
        for (int j = 0; j < 8; j++) begin
          x = (low >> j) & 1;
          y = int'(d[j]);
          if (j < ac) begin
            dif[j] = y[0];
            bo     = (x == 1 && y == 0) ? 1 : 0;
          end else begin
            t      = x - y - bo;
            dif[j] = t[0];
            bo     = (t < 0) ? 1 : 0;
          end
        end
        take = (top == 1) || (bo == 0);
        nr   = take ? int'(dif) : low;
      end
      q[k] = take;
      r    = nr[7:0];
      rem  = nr * 2;
      if (k > 0) rem = rem + int'(n[k-1]);
    end
  endfunction

  task automatic send(input logic [ND-1:0] m, input logic [15:0] nn,
                      input logic [7:0] dd, output bit to);
    int c;
    c  = 0;
    to = 0;
    @(negedge clk);
    while ((ir & m) != m && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) to = 1;
    tn = nn;
    td = dd;
    iv = m;
    @(posedge clk);
    #1 iv = '0;
  endtask

  task automatic wait_ov(input int g, input int maxc,
                         output int cyc, output bit to);
    cyc = 0;
    while (!ov[g] && cyc < maxc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    to = !ov[g];
  endtask

  task automatic consume(input logic [ND-1:0] m);
    @(negedge clk);
    ordy = m;
    @(negedge clk);
    ordy = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int g = 0; g < ND; g++) begin
      n_checks++;
      if ({ir[g], ov[g], ovfo[g], dzo[g], qo[g], ro[g]} !== 20'd0) begin
        n_err++;
        $display("FAIL reset_state dut%0d got ir=%b ov=%b ovf=%b dz=%b q=%h r=%h want all 0",
                 g, ir[g], ov[g], ovfo[g], dzo[g], qo[g], ro[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      n_checks++;
      if (ir[g] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready dut%0d got %b want 1", g, ir[g]);
      end
    end
  endtask

  task automatic test_exact_basic;
    bit to;
    int cyc;
    logic [7:0] eq, er;
    logic eo, ez;
    send(4'hF, 16'd1000, 8'd7, to);
    wait_ov(0, 20, cyc, to);
    n_checks++;
    if (to || cyc != 8) begin
      n_err++;
      $display("FAIL latency_rpc1 got %0d cycles (timeout=%0d) want 8", cyc, to);
    end
    for (int g = 1; g < ND; g++) wait_ov(g, 20, cyc, to);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({qo[g], ro[g], ovfo[g], dzo[g]} !== {8'd142, 8'd6, 2'b00}) begin
        n_err++;
        $display("FAIL div_1000_7 dut%0d got q=%0d r=%0d ovf=%b dz=%b want 142 6 0 0",
                 g, qo[g], ro[g], ovfo[g], dzo[g]);
      end
    end
    for (int g = 2; g < ND; g++) begin
      model(16'd1000, 8'd7, P_AR[g], P_AC[g], eq, er, eo, ez);
      n_checks++;
      if ({ov[g], qo[g], ro[g], ovfo[g], dzo[g]} !== {1'b1, eq, er, eo, ez}) begin
        n_err++;
        $display("FAIL div_1000_7_apx dut%0d got v=%b q=%h r=%h ovf=%b dz=%b want q=%h r=%h ovf=%b dz=%b",
                 g, ov[g], qo[g], ro[g], ovfo[g], dzo[g], eq, er, eo, ez);
      end
    end
    consume(4'hF);
  endtask

  task automatic test_approx;
    bit to;
    int cyc;
    logic [7:0] wq, wr;
`ifdef SEQ_APPROX_DIV_FORCE_EXACT_EN
    wq = 8'h03;
    wr = 8'h00;
`else
    wq = 8'hFF;
    wr = 8'h01;
`endif
    send(4'hF, 16'h0003, 8'h01, to);
    for (int g = 0; g < ND; g++) wait_ov(g, 20, cyc, to);
    n_checks++;
    if ({ov[2], qo[2], ro[2]} !== {1'b1, wq, wr}) begin
      n_err++;
      $display("FAIL approx_3_1 got v=%b q=%h r=%h want q=%h r=%h",
               ov[2], qo[2], ro[2], wq, wr);
    end
    n_checks++;
    if ({ov[0], qo[0], ro[0]} !== {1'b1, 8'h03, 8'h00}) begin
      n_err++;
      $display("FAIL exact_3_1 got v=%b q=%h r=%h want q=03 r=00",
               ov[0], qo[0], ro[0]);
    end
    consume(4'hF);
  endtask

  task automatic test_div_zero;
    bit to;
    int cyc;
    send(4'hF, 16'h1234, 8'h00, to);
    for (int g = 0; g < ND; g++) begin
      wait_ov(g, 20, cyc, to);
      n_checks++;
      if ({to, dzo[g], qo[g], ro[g]} !== {1'b0, 1'b1, 8'hFF, 8'h34}) begin
        n_err++;
        $display("FAIL div_zero dut%0d got to=%b dz=%b q=%h r=%h want dz=1 q=FF r=34",
                 g, to, dzo[g], qo[g], ro[g]);
      end
    end
    consume(4'hF);
  endtask

  task automatic test_overflow;
    bit to;
    int cyc;
    logic [7:0] eq, er;
    logic eo, ez;
    send(4'hF, 16'h0800, 8'h08, to);
    for (int g = 0; g < ND; g++) begin
      wait_ov(g, 20, cyc, to);
      model(16'h0800, 8'h08, P_AR[g], P_AC[g], eq, er, eo, ez);
      n_checks++;
      if ({to, ovfo[g], dzo[g], qo[g], ro[g]} !== {1'b0, 1'b1, 1'b0, eq, er}) begin
        n_err++;
        $display("FAIL overflow dut%0d got to=%b ovf=%b dz=%b q=%h r=%h want ovf=1 dz=0 q=%h r=%h",
                 g, to, ovfo[g], dzo[g], qo[g], ro[g], eq, er);
      end
    end
    consume(4'hF);
  endtask

  task automatic test_rows_per_cycle;
    bit to;
    int cyc;
    send(4'b0010, 16'd1000, 8'd7, to);
    wait_ov(1, 20, cyc, to);
    n_checks++;
    if (to || cyc != 2 || qo[1] !== 8'd142 || ro[1] !== 8'd6) begin
      n_err++;
      $display("FAIL rpc4_result got cyc=%0d q=%0d r=%0d want cyc=2 q=142 r=6",
               cyc, qo[1], ro[1]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tn = 16'($urandom);
      td = 8'($urandom_range(1, 255));
      iv = 4'b0010;
      n_checks++;
      if ({ov[1], ir[1], qo[1], ro[1]} !== {1'b1, 1'b0, 8'd142, 8'd6}) begin
        n_err++;
        $display("FAIL stall_hold c%0d got v=%b ir=%b q=%0d r=%0d want v=1 ir=0 q=142 r=6",
                 c, ov[1], ir[1], qo[1], ro[1]);
      end
    end
    iv = '0;
    consume(4'b0010);
  endtask

  task automatic test_back_to_back;
    bit to;
    int cyc;
    send(4'b0001, 16'd1000, 8'd7, to);
    wait_ov(0, 20, cyc, to);
    @(negedge clk);
    tn   = 16'd255;
    td   = 8'd16;
    iv   = 4'b0001;
    ordy = 4'b0001;
    #1;
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready got %b want 1", ir[0]);
    end
    @(posedge clk);
    #1;
    iv   = '0;
    ordy = '0;
    n_checks++;
    if (ov[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept got ov=%b want 0", ov[0]);
    end
    wait_ov(0, 20, cyc, to);
    n_checks++;
    if (to || cyc != 8 || qo[0] !== 8'd15 || ro[0] !== 8'd15) begin
      n_err++;
      $display("FAIL b2b_second got cyc=%0d q=%0d r=%0d want cyc=8 q=15 r=15",
               cyc, qo[0], ro[0]);
    end
    consume(4'b0001);
  endtask

  task automatic test_reset_mid;
    bit to;
    int cyc;
    send(4'b0001, 16'd1000, 8'd7, to);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov[0], ir[0], qo[0], ro[0]} !== 18'd0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b ir=%b q=%h r=%h want all 0",
               ov[0], ir[0], qo[0], ro[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_ready got %b want 1", ir[0]);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (ov[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_no_result got ov=%b want 0", ov[0]);
    end
    send(4'b0001, 16'd255, 8'd16, to);
    wait_ov(0, 20, cyc, to);
    n_checks++;
    if (to || qo[0] !== 8'd15 || ro[0] !== 8'd15) begin
      n_err++;
      $display("FAIL after_reset_op got to=%b q=%0d r=%0d want 15 15",
               to, qo[0], ro[0]);
    end
    consume(4'b0001);
  endtask

  task automatic test_random;
    bit to;
    int cyc;
    logic [15:0] n;
    logic [7:0] d, eq, er;
    logic eo, ez;
    for (int it = 0; it < 40; it++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = 8'd0;
      if (d != 0 && $urandom_range(0, 3) != 0)
        n = {8'($urandom_range(0, int'(d) - 1)), 8'($urandom)};
      else
        n = 16'($urandom);
      send(4'hF, n, d, to);
      for (int g = 0; g < ND; g++) begin
        wait_ov(g, 20, cyc, to);
        model(n, d, P_AR[g], P_AC[g], eq, er, eo, ez);
        n_checks++;
        if ({to, qo[g], ro[g], ovfo[g], dzo[g]} !== {1'b0, eq, er, eo, ez}) begin
          n_err++;
          $display("FAIL random dut%0d n=%h d=%h got to=%b q=%h r=%h ovf=%b dz=%b want q=%h r=%h ovf=%b dz=%b",
                   g, n, d, to, qo[g], ro[g], ovfo[g], dzo[g], eq, er, eo, ez);
        end
      end
      consume(4'hF);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    iv       = '0;
    ordy     = '0;
    tn       = '0;
    td       = '0;
    test_reset();
    test_exact_basic();
    test_approx();
    test_div_zero();
    test_overflow();
    test_rows_per_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
